// File: rtl/branch_history_table.sv
// branch_history_table: 2-bit saturating-counter branch predictor with
// a zero-latency combinational lookup for the fetch PC, training from the
// resolved branch in ID/EX, and saturating branch/mispredict counters.
//
// Optional build macro: BHT_GSHARE_EN
//   undefined -> bimodal indexing, idx = pc[IDX_BITS+1:2]
//   defined   -> gshare indexing, idx ^ global history; adds pred_ghr/upd_ghr
module branch_history_table #(
    parameter int unsigned IDX_BITS   = 6,
    parameter logic [1:0]  INIT_STATE = 2'b01,
    parameter int unsigned CNT_BITS   = 16,
    parameter int unsigned GHR_BITS   = 6
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [31:0]         pc_if,
    output logic [1:0]          state,
    input  logic                stall,
    input  logic                upd_valid,
    input  logic [31:0]         upd_pc,
    input  logic                outcome,
`ifdef BHT_GSHARE_EN
    output logic [GHR_BITS-1:0] pred_ghr,
    input  logic [GHR_BITS-1:0] upd_ghr,
`endif
    output logic                mispredict,
    output logic [CNT_BITS-1:0] br_count,
    output logic [CNT_BITS-1:0] mispred_count
);

    localparam int unsigned ENTRIES = 1 << IDX_BITS;

    logic [1:0]          bht [ENTRIES];
    logic [IDX_BITS-1:0] rd_idx;
    logic [IDX_BITS-1:0] upd_idx;
    logic                accept;
    logic [1:0]          ctr_cur;
    logic [1:0]          ctr_next;

    // PC bits outside the index field carry no prediction information.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{pc_if[31:IDX_BITS+2], pc_if[1:0],
                              upd_pc[31:IDX_BITS+2], upd_pc[1:0]};

`ifdef BHT_GSHARE_EN
    logic [GHR_BITS-1:0] ghr;

    // History is folded into the low index bits; the update side uses the
    // snapshot taken at prediction time so training hits the same entry.
    assign rd_idx   = pc_if[IDX_BITS+1:2]  ^ IDX_BITS'(ghr);
    assign upd_idx  = upd_pc[IDX_BITS+1:2] ^ IDX_BITS'(upd_ghr);
    assign pred_ghr = ghr;

    // Global history shifts in every accepted branch outcome.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ghr <= '0;
        end else if (accept) begin
            ghr <= {ghr[GHR_BITS-2:0], outcome};
        end
    end
`else
    logic [GHR_BITS-1:0] unused_ghr_width;
    assign unused_ghr_width = '0;

    assign rd_idx  = pc_if[IDX_BITS+1:2];
    assign upd_idx = upd_pc[IDX_BITS+1:2];
`endif

    assign accept = upd_valid & ~stall;

    // Lookup is purely combinational; an update in the same cycle only
    // becomes visible after the clock edge (no bypass).
    assign state   = bht[rd_idx];
    assign ctr_cur = bht[upd_idx];

    // Saturating increment/decrement of the counter being trained.
    always_comb begin
        ctr_next = ctr_cur;
        if (outcome) begin
            if (ctr_cur != 2'b11) ctr_next = ctr_cur + 2'd1;
        end else begin
            if (ctr_cur != 2'b00) ctr_next = ctr_cur - 2'd1;
        end
    end

    assign mispredict = accept & (ctr_cur[1] != outcome);

    // Counter table: whole table returns to INIT_STATE on reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                bht[i] <= INIT_STATE;
            end
        end else if (accept) begin
            bht[upd_idx] <= ctr_next;
        end
    end

    // Perf counters stick at all-ones rather than wrapping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            br_count      <= '0;
            mispred_count <= '0;
        end else begin
            if (accept && (br_count != '1)) begin
                br_count <= br_count + CNT_BITS'(1);
            end
            if (mispredict && (mispred_count != '1)) begin
                mispred_count <= mispred_count + CNT_BITS'(1);
            end
        end
    end

endmodule

// File: tb/tb_branch_history_table.sv
// Directed testbench for branch_history_table (bimodal build).
// Perf counters are narrowed to 4 bits so their saturation is reachable.
module tb_branch_history_table;

    localparam int unsigned CNT_W = 4;
    localparam int unsigned GHR_W = 6;

    logic             clk;
    logic             reset;
    logic [31:0]      pc_if;
    logic [1:0]       state;
    logic             stall;
    logic             upd_valid;
    logic [31:0]      upd_pc;
    logic             outcome;
    logic             mispredict;
    logic [CNT_W-1:0] br_count;
    logic [CNT_W-1:0] mispred_count;
`ifdef BHT_GSHARE_EN
    logic [GHR_W-1:0] pred_ghr;
    logic [GHR_W-1:0] upd_ghr;
`endif

    int n_checks;
    int n_fails;

    branch_history_table #(
        .IDX_BITS   (6),
        .INIT_STATE (2'b01),
        .CNT_BITS   (CNT_W),
        .GHR_BITS   (GHR_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .pc_if         (pc_if),
        .state         (state),
        .stall         (stall),
        .upd_valid     (upd_valid),
        .upd_pc        (upd_pc),
        .outcome       (outcome),
`ifdef BHT_GSHARE_EN
        .pred_ghr      (pred_ghr),
        .upd_ghr       (upd_ghr),
`endif
        .mispredict    (mispredict),
        .br_count      (br_count),
        .mispred_count (mispred_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_upd(input logic v, input logic [31:0] pc, input logic o);
        upd_valid = v;
        upd_pc    = pc;
        outcome   = o;
    endtask

    // Assert reset between clock edges and check it takes effect at once.
    task automatic async_reset_pulse(input string tag);
        #3 reset = 1'b0;
        #1;
        check_val({tag, "_state"}, 32'(state), 32'h1);
        check_val({tag, "_br"}, 32'(br_count), 32'h0);
        check_val({tag, "_mis"}, 32'(mispred_count), 32'h0);
        #2 reset = 1'b1;
    endtask

    initial begin
        logic [1:0] sat_up [4];
        logic [1:0] sat_dn [5];
        sat_up = '{2'b10, 2'b11, 2'b11, 2'b11};
        sat_dn = '{2'b10, 2'b01, 2'b00, 2'b00, 2'b00};
        n_checks = 0;
        n_fails  = 0;
        reset = 1'b0;
        pc_if = 32'h0;
        stall = 1'b0;
        set_upd(1'b0, 32'h0, 1'b0);
`ifdef BHT_GSHARE_EN
        upd_ghr = '0;
`endif

        // Reset values
        #12 reset = 1'b1;
        #1;
        pc_if = 32'h0;  #1 check_val("rst_pc0",  32'(state), 32'h1);
        pc_if = 32'h4;  #1 check_val("rst_pc4",  32'(state), 32'h1);
        pc_if = 32'hFC; #1 check_val("rst_pcfc", 32'(state), 32'h1);
        check_val("rst_br",  32'(br_count), 32'h0);
        check_val("rst_mis", 32'(mispred_count), 32'h0);
        check_val("rst_mp",  32'(mispredict), 32'h0);

        // Saturation up then down at pc 0x40
        step();
        pc_if = 32'h40;
        set_upd(1'b1, 32'h40, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step();
            check_val($sformatf("sat_up%0d", i), 32'(state), 32'(sat_up[i]));
        end
        outcome = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check_val($sformatf("sat_dn%0d", i), 32'(state), 32'(sat_dn[i]));
        end
        upd_valid = 1'b0;
        // 9 accepted; mispredicts on stored 01 (taken), 11 and 10 (not-taken)
        check_val("sat_br",  32'(br_count), 32'd9);
        check_val("sat_mis", 32'(mispred_count), 32'd3);

        // Async reset mid-cycle
        check_val("pre_rst_state", 32'(state), 32'h0);
        async_reset_pulse("arst");

        // Mispredict counting at 0x80
        step();
        pc_if = 32'h80;
        set_upd(1'b1, 32'h80, 1'b1);
        #1 check_val("mp_first", 32'(mispredict), 32'h1);
        step();
        check_val("mp_second", 32'(mispredict), 32'h0);
        step();
        upd_valid = 1'b0;
        #1;
        check_val("mp_br",    32'(br_count), 32'd2);
        check_val("mp_mis",   32'(mispred_count), 32'd1);
        check_val("mp_state", 32'(state), 32'h3);

        // Same-index read/update collision at 0x100: no bypass
        pc_if = 32'h100;
        set_upd(1'b1, 32'h100, 1'b1);
        #1 check_val("coll_same", 32'(state), 32'h1);
        step();
        upd_valid = 1'b0;
        #1 check_val("coll_next", 32'(state), 32'h2);

        // Aliasing: 0x200 and 0x0 share index 0 with 0x100
        pc_if = 32'h200; #1 check_val("alias_200", 32'(state), 32'h2);
        pc_if = 32'h0;   #1 check_val("alias_0",   32'(state), 32'h2);

        // Stall blocks an update that would otherwise mispredict
        pc_if = 32'h100;
        stall = 1'b1;
        set_upd(1'b1, 32'h100, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1 check_val($sformatf("stall_mp%0d", i), 32'(mispredict), 32'h0);
            step();
            check_val($sformatf("stall_st%0d", i), 32'(state), 32'h2);
        end
        check_val("stall_br",  32'(br_count), 32'd3);
        check_val("stall_mis", 32'(mispred_count), 32'd2);
        stall = 1'b0;
        #1 check_val("unstall_mp", 32'(mispredict), 32'h1);
        step();
        upd_valid = 1'b0;
        #1;
        check_val("unstall_st",  32'(state), 32'h1);
        check_val("unstall_br",  32'(br_count), 32'd4);
        check_val("unstall_mis", 32'(mispred_count), 32'd3);

        // Perf counter saturation: alternating outcomes at 0xFC mispredict every time
        pc_if = 32'hFC;
        for (int i = 0; i < 20; i++) begin
            set_upd(1'b1, 32'hFC, ((i % 2) == 0) ? 1'b1 : 1'b0);
            step();
        end
        upd_valid = 1'b0;
        #1;
        check_val("psat_br",  32'(br_count), 32'hF);
        check_val("psat_mis", 32'(mispred_count), 32'hF);
        check_val("psat_st",  32'(state), 32'h1);

        // Second async reset clears saturated counters immediately
        async_reset_pulse("arst2");
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
